// File: rtl/imem_access_ctrl_pkg.sv
// Shared types and constants for the instruction-memory access controller.
package imem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_PROG_ACC,
      ST_PROG_ACK
   } state_t;

   localparam logic [7:0] WR_COUNT_MAX = 8'hFF;

   localparam logic [1:0] LANE_0 = 2'd0;
   localparam logic [1:0] LANE_1 = 2'd1;
   localparam logic [1:0] LANE_2 = 2'd2;
   localparam logic [1:0] LANE_3 = 2'd3;

   // Byte lane of a little-endian 32-bit word.
   function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         LANE_0:  b = word[7:0];
         LANE_1:  b = word[15:8];
         LANE_2:  b = word[23:16];
         LANE_3:  b = word[31:24];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/imem_access_ctrl_if.sv
// Fetch, programming, memory and status signals of the instruction-memory
// access controller. The controller uses the slave view.
interface imem_access_ctrl_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 32
);
   logic               i_fetch_req;
   logic [ADDR_W-1:0]  i_fetch_addr;
   logic               o_fetch_gnt;
   logic               o_fetch_valid;
   logic [INSTR_W-1:0] o_fetch_instr;
   logic               o_fetch_err;

   logic               i_prog_mode;
   logic               i_prog_req;
   logic               i_prog_we;
   logic [ADDR_W-1:0]  i_prog_addr;
   logic [7:0]         i_prog_wdata;
   logic               o_prog_ack;
   logic [7:0]         o_prog_rdata;
   logic               o_prog_err;

   logic               o_core_stall;

   logic [ADDR_W-1:0]  o_mem_addr;
   logic [7:0]         o_mem_wdata;
   logic               o_mem_we;
   logic [INSTR_W-1:0] i_mem_rdata;

   logic [7:0]         o_wr_count;

   modport slave (
      input  i_fetch_req, i_fetch_addr,
      output o_fetch_gnt, o_fetch_valid, o_fetch_instr, o_fetch_err,
      input  i_prog_mode, i_prog_req, i_prog_we, i_prog_addr, i_prog_wdata,
      output o_prog_ack, o_prog_rdata, o_prog_err,
      output o_core_stall,
      output o_mem_addr, o_mem_wdata, o_mem_we,
      input  i_mem_rdata,
      output o_wr_count
   );

   modport master (
      output i_fetch_req, i_fetch_addr,
      input  o_fetch_gnt, o_fetch_valid, o_fetch_instr, o_fetch_err,
      output i_prog_mode, i_prog_req, i_prog_we, i_prog_addr, i_prog_wdata,
      input  o_prog_ack, o_prog_rdata, o_prog_err,
      input  o_core_stall,
      input  o_mem_addr, o_mem_wdata, o_mem_we,
      output i_mem_rdata,
      input  o_wr_count
   );
endinterface

// File: rtl/imem_access_ctrl_bit_sync.sv
// Flop-chain synchroniser for one asynchronous level into the core clock.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] chain;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) chain <= '0;
      else        chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];
endmodule

// File: rtl/imem_access_ctrl.sv
// Instruction-memory sequencer: serialises core fetches and asynchronous
// programming-port accesses onto the single memory port.
//
// state       | meaning
// ST_IDLE     | waiting; a synchronised programming request beats a fetch
// ST_FETCH    | memory word returned to the core with valid
// ST_PROG_ACC | programming write, read or reject performed
// ST_PROG_ACK | ack held until the synchronised request drops
module imem_access_ctrl
   import imem_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int INSTR_W     = 32,
   parameter int SYNC_STAGES = 2
) (
   input logic               i_clk,
   input logic               i_nrst,
   imem_access_ctrl_if.slave bus
);
   state_t             state, state_nx;
   logic               mode_s, req_s, mode_d;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [7:0]         mem_wdata_q;
   logic [7:0]         prog_rdata_q;
   logic [7:0]         wr_count_q, wr_count_nx;
   logic [INSTR_W-1:0] instr_q;
   logic               ack_q, err_q;
   logic               take_prog, take_fetch;
   logic               fetch_gnt, fetch_valid, fetch_err, mem_we;

   bit_sync #(.STAGES(SYNC_STAGES)) u_sync_mode (
      .clk_sys (i_clk),
      .rst_b   (i_nrst),
      .d       (bus.i_prog_mode),
      .q       (mode_s)
   );

   bit_sync #(.STAGES(SYNC_STAGES)) u_sync_req (
      .clk_sys (i_clk),
      .rst_b   (i_nrst),
      .d       (bus.i_prog_req),
      .q       (req_s)
   );

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) state <= ST_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      take_prog   = 1'b0;
      take_fetch  = 1'b0;
      fetch_gnt   = 1'b0;
      fetch_valid = 1'b0;
      fetch_err   = 1'b0;
      mem_we      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_s && !ack_q) begin
               take_prog = 1'b1;
               state_nx  = ST_PROG_ACC;
            end else if (bus.i_fetch_req && !mode_s) begin
               take_fetch = 1'b1;
               fetch_gnt  = 1'b1;
               state_nx   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            fetch_valid = 1'b1;
            fetch_err   = (mem_addr_q[1:0] != 2'b00);
            state_nx    = ST_IDLE;
         end
         ST_PROG_ACC: begin
            mem_we   = mode_s && bus.i_prog_we;
            state_nx = ST_PROG_ACK;
         end
         ST_PROG_ACK: begin
            if (!req_s) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // A new programming session restarts the write tally, then counts this cycle's write.
   always_comb begin
      wr_count_nx = (mode_s && !mode_d) ? 8'h00 : wr_count_q;
      if (mem_we && wr_count_nx != WR_COUNT_MAX) wr_count_nx = wr_count_nx + 8'h01;
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         mode_d       <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 8'h00;
         prog_rdata_q <= 8'h00;
         wr_count_q   <= 8'h00;
         instr_q      <= '0;
         ack_q        <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         mode_d     <= mode_s;
         wr_count_q <= wr_count_nx;
         if (take_prog) begin
            mem_addr_q  <= bus.i_prog_addr;
            mem_wdata_q <= bus.i_prog_wdata;
         end else if (take_fetch) begin
            mem_addr_q <= bus.i_fetch_addr;
         end
         if (fetch_valid) instr_q <= bus.i_mem_rdata;
         if (state == ST_PROG_ACC) begin
            ack_q <= 1'b1;
            err_q <= !mode_s;
            if (mode_s && !bus.i_prog_we)
               prog_rdata_q <= lane_sel(bus.i_mem_rdata[31:0], mem_addr_q[1:0]);
         end else if (state == ST_PROG_ACK && !req_s) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
         end
      end
   end

   // The fetched word is presented straight from memory during the valid cycle, then held.
   assign bus.o_fetch_instr = (state == ST_FETCH) ? bus.i_mem_rdata : instr_q;
   assign bus.o_fetch_gnt   = fetch_gnt;
   assign bus.o_fetch_valid = fetch_valid;
   assign bus.o_fetch_err   = fetch_err;
   assign bus.o_prog_ack    = ack_q;
   assign bus.o_prog_err    = err_q;
   assign bus.o_prog_rdata  = prog_rdata_q;
   assign bus.o_core_stall  = mode_s;
   assign bus.o_mem_addr    = mem_addr_q;
   assign bus.o_mem_wdata   = mem_wdata_q;
   assign bus.o_mem_we      = mem_we;
   assign bus.o_wr_count    = wr_count_q;
endmodule
